subleq_sequencer: RTL
=====================

# subleq_sequencer

Instruction sequencer for the Subleq CPU. It fetches the three-word instruction at `pc` over a single shared memory port, reads both operands, writes back `M[b] - M[a]`, and updates `pc`. It supports free-run, single-step and halt. Memory accesses use a req/ack handshake, so the core works with variable-latency RAM and with a port shared through an external arbiter.

## Interface
Parameters:
- `ADDR_W`, 8: address width; `pc` and operand addresses.
- `DATA_W`, 8: memory word width; two's-complement data. `DATA_W` ≥ `ADDR_W`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `run`  in  1  level; while high, execute instructions back-to-back.
- `step`  in  1  single-cycle pulse; in IDLE with `run` low, execute exactly one instruction.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  access complete.
- `pc`  out  ADDR_W  current program counter.
- `busy`  out  1  high in any state other than IDLE or HALT.
- `halted`  out  1  high in HALT; sticky.
- `retired`  out  1  one-cycle pulse when an instruction completes.

## Operation
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, HALT.
- Memory states and their accesses:
  - FETCH_A: read `pc` into `opa`.
  - FETCH_B: read `pc+1` into `opb`.
  - FETCH_C: read `pc+2` into `opc`.
  - READ_A: read `opa` into `va`.
  - READ_B: read `opb` into `vb`.
  - WRITE_B: write `vb - va` to address `opb`.
- Operand addresses are taken from the low `ADDR_W` bits of the fetched word.
- Each memory state holds `mem_req`=1 and constant `mem_addr`/`mem_we`/`mem_wdata`. The state advances only on an edge where `mem_ack`=1, and read data is captured on that edge.
- Arithmetic: `res = vb - va`, `DATA_W` bits, wraps modulo 2^DATA_W. Branch is taken when `res == 0` or `res[DATA_W-1] == 1`.
- `pc` arithmetic is modulo 2^ADDR_W. `pc+1` and `pc+2` wrap, and the not-taken next `pc` is `pc+3` wrapped.
- On WRITE_B ack:
  - If branch taken and `opc` is all-ones: go to HALT and leave `pc` unchanged.
  - Otherwise: update `pc` (to `opc` if taken, else `pc+3`), pulse `retired`, then go to FETCH_A if `run`=1, else to IDLE.
- The write to `M[b]` always completes before a halt.
- IDLE: go to FETCH_A if `run`=1 or `step`=1; otherwise stay. A `step` outside IDLE is ignored.
- Dropping `run` mid-instruction does not abort; the current instruction completes.
- HALT: absorbing. `run` and `step` are ignored, `mem_req`=0, and only `rst_n` exits.
- `mem_ack` while `mem_req`=0 is ignored.
- Self-modifying code is legal: fetches always re-read memory, with no caching.
- Reset mid-access: `mem_req` drops immediately (asynchronously) and the pending access is abandoned.

## Timing
- Reset values: state=IDLE, `pc`=0, `opa`/`opb`/`opc`/`va`/`vb`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `halted`=0, `retired`=0.
- All outputs are registered or decoded solely from registers. There is no combinational path from `mem_ack`/`mem_rdata` to outputs.
- `mem_req` rises in the cycle after the IDLE edge that sampled `run`/`step`.
- With zero-wait memory (`mem_ack` high whenever `mem_req` is high), an instruction takes exactly 6 cycles. Back-to-back instructions under `run` take 6 cycles each, with no IDLE bubble.
- Each wait cycle (`mem_req`=1, `mem_ack`=0) adds exactly one cycle.
- `retired` and the new `pc` become visible in the cycle after the WRITE_B ack edge, which is also the first cycle of the next FETCH_A.
- `halted` rises in the cycle after the WRITE_B ack edge that detects halt.

## Structure
- `subleq_pkg` holds the state enum type `seq_state_t` and the default `ADDR_W`/`DATA_W` constants, shared with the datapath and testbenches.
- No sub-module: the subtractor and branch test are inline and small. The block is a single FSM plus operand and `pc` registers.

## Test plan
- Reset, then `run`=1 with zero-wait RAM holding `M[0..2]`={3,4,6}, `M[3]`=2, `M[4]`=5 → `M[4]`=3, not taken, `pc`=3 after 6 cycles, one `retired` pulse.
- `M[0..2]`={3,4,9}, `M[3]`=5, `M[4]`=5 → `M[4]`=0, taken, `pc`=9. Repeat with `M[4]`=2 → `M[4]`=0xFD, taken.
- Instruction with `c`=0xFF whose result is ≤ 0 → `M[b]` written, `halted`=1, `pc` unchanged, `mem_req` stays 0 with `run` held high for 20 cycles.
- `run`=0, one `step` pulse → exactly one instruction, then IDLE; a `step` pulsed while `busy` is ignored.
- Random 0–3 wait states per access → memory and `pc` results identical to the zero-wait run; address, we and wdata stay stable across each wait.
- Assert `rst_n`=0 during READ_B → `mem_req` falls immediately; after release, `pc`=0, state=IDLE, and no write occurs.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared types and default widths for the Subleq sequencer, its datapath
// users and testbenches.
package subleq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    FETCH_C = 3'd3,
    READ_A  = 3'd4,
    READ_B  = 3'd5,
    WRITE_B = 3'd6,
    HALT    = 3'd7
  } seq_state_t;

  // States that own the memory port and hold mem_req high.
  function automatic logic is_mem_state(input seq_state_t s);
    return (s != IDLE) && (s != HALT);
  endfunction

endpackage

// File: rtl/subleq_sequencer.sv
// Subleq instruction sequencer: fetch a,b,c at pc, compute M[b]-M[a], write it
// back and branch to c when the result is <= 0. One shared req/ack memory port.
module subleq_sequencer
  import subleq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              retired,
  output seq_state_t        state_dbg
);

  // Memory handshake: while mem_req is high, mem_addr/mem_we/mem_wdata are
  // held constant; the access completes on the first rising edge with
  // mem_ack=1 (read data captured on that edge). mem_ack with mem_req low is
  // ignored. Every port output decodes from registers only.

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] opa_q, opb_q, opc_q;
  logic [DATA_W-1:0] va_q, vb_q;
  logic              retired_q;

  logic [DATA_W-1:0] res;
  logic              taken;
  logic              halt_hit;

  assign res      = vb_q - va_q;
  assign taken    = (res == '0) || res[DATA_W-1];
  assign halt_hit = taken && (&opc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run || step) state_d = FETCH_A;
      FETCH_A: if (mem_ack) state_d = FETCH_B;
      FETCH_B: if (mem_ack) state_d = FETCH_C;
      FETCH_C: if (mem_ack) state_d = READ_A;
      READ_A:  if (mem_ack) state_d = READ_B;
      READ_B:  if (mem_ack) state_d = WRITE_B;
      WRITE_B: begin
        if (mem_ack) begin
          if (halt_hit)  state_d = HALT;
          else if (run)  state_d = FETCH_A;
          else           state_d = IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Operand, pc and retire registers; updates only on an acked access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      va_q      <= '0;
      vb_q      <= '0;
      retired_q <= 1'b0;
    end else begin
      retired_q <= 1'b0;
      if (mem_ack) begin
        unique case (state_q)
          FETCH_A: opa_q <= mem_rdata[ADDR_W-1:0];
          FETCH_B: opb_q <= mem_rdata[ADDR_W-1:0];
          FETCH_C: opc_q <= mem_rdata[ADDR_W-1:0];
          READ_A:  va_q  <= mem_rdata;
          READ_B:  vb_q  <= mem_rdata;
          WRITE_B: begin
            if (!halt_hit) begin
              pc_q      <= taken ? opc_q : pc_q + ADDR_W'(3);
              retired_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      FETCH_A: mem_addr = pc_q;
      FETCH_B: mem_addr = pc_q + ADDR_W'(1);
      FETCH_C: mem_addr = pc_q + ADDR_W'(2);
      READ_A:  mem_addr = opa_q;
      READ_B:  mem_addr = opb_q;
      WRITE_B: mem_addr = opb_q;
      default: mem_addr = '0;
    endcase
  end

  assign mem_req   = is_mem_state(state_q);
  assign mem_we    = (state_q == WRITE_B);
  assign mem_wdata = (state_q == WRITE_B) ? res : '0;
  assign pc        = pc_q;
  assign busy      = is_mem_state(state_q);
  assign halted    = (state_q == HALT);
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule
